// File: rtl/seq_elem_pkg.sv
// Shared definitions for the SR storage elements (D-, JK- and T-based variants).
// Holds the forbidden-input policy encoding, the reset value and the per-bit SR rule.
package seq_elem_pkg;

    localparam int   SET_WINS   = 1;
    localparam int   RESET_WINS = 0;
    localparam logic RESET_VAL  = 1'b0;

    // S=R=1 resolves to set_wins, so the result is never X.
    function automatic logic sr_next(
        input logic s,
        input logic r,
        input logic q,
        input logic set_wins
    );
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b00:   nxt = q;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            default: nxt = set_wins;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/d_ff_async.sv
// WIDTH-bit rising-edge D register with asynchronous active-low clear.
// This is the only storage in the SR element.
module d_ff_async
    import seq_elem_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {WIDTH{RESET_VAL}};
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sr_using_d.sv
// Clocked SR flip-flop: per-bit S/R converted to a D input, stored in d_ff_async.
// Q_bar is the inverse of the same register, so Q and Q_bar always differ.
module sr_using_d
    import seq_elem_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int SET_DOMINANT = SET_WINS
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    input  logic             rst
);

    localparam logic SET_WINS_BIT = (SET_DOMINANT == SET_WINS);

    generate
        if (WIDTH < 1 || (SET_DOMINANT != SET_WINS && SET_DOMINANT != RESET_WINS)) begin : g_bad_param
            $error("sr_using_d: WIDTH must be >= 1 and SET_DOMINANT must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] state_q;

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = sr_next(S[i], R[i], state_q[i], SET_WINS_BIT);
        end
    end

    d_ff_async #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk   (clk),
        .rst_n (rst),
        .d     (state_d),
        .q     (state_q)
    );

    assign Q     = state_q;
    assign Q_bar = ~state_q;

endmodule

// File: tb/tb_sr_using_d.sv
// Directed bench for sr_using_d: set-dominant and reset-dominant 1-bit copies
// plus a 4-bit copy, all sharing one clock and one reset.
module tb_sr_using_d;

    logic       clk;
    logic       rst;
    logic       s1, r1, q1, qb1;
    logic       s0, r0, q0, qb0;
    logic [3:0] s4, r4, q4, qb4;

    int checks = 0;
    int errors = 0;

    sr_using_d #(.WIDTH(1), .SET_DOMINANT(1)) dut_set (
        .clk(clk), .S(s1), .R(r1), .Q(q1), .Q_bar(qb1), .rst(rst)
    );

    sr_using_d #(.WIDTH(1), .SET_DOMINANT(0)) dut_rst (
        .clk(clk), .S(s0), .R(r0), .Q(q0), .Q_bar(qb0), .rst(rst)
    );

    sr_using_d #(.WIDTH(4), .SET_DOMINANT(1)) dut_w4 (
        .clk(clk), .S(s4), .R(r4), .Q(q4), .Q_bar(qb4), .rst(rst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("t=%0t check %s observed=%b expected=%b", $time, tag, obs, exp);
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        s1 = 1'b1; r1 = 1'b0;
        s0 = 1'b1; r0 = 1'b0;
        s4 = 4'hF; r4 = 4'h0;
        #1;
        check("rst_init_q", {3'b0, q1}, 4'b0000);
        check("rst_init_qb", {3'b0, qb1}, 4'b0001);

        // Reset held with S asserted and clock running
        for (int i = 0; i < 3; i++) begin
            after_edge();
            check("rst_hold_q", {3'b0, q1}, 4'b0000);
            check("rst_hold_qb", {3'b0, qb1}, 4'b0001);
        end
        check("rst_hold_q0", {3'b0, q0}, 4'b0000);
        check("rst_hold_w4_q", q4, 4'b0000);
        check("rst_hold_w4_qb", qb4, 4'b1111);

        @(negedge clk);
        rst = 1'b1;
        s1 = 1'b0; r1 = 1'b0; s0 = 1'b0; r0 = 1'b0; s4 = 4'h0; r4 = 4'h0;
        after_edge();
        check("release_q", {3'b0, q1}, 4'b0000);

        // Set-dominant sequence
        @(negedge clk); s1 = 0; r1 = 0; after_edge(); check("seq00_a", {3'b0, q1}, 4'b0000);
        @(negedge clk); s1 = 0; r1 = 1; after_edge(); check("seq01", {3'b0, q1}, 4'b0000);
        @(negedge clk); s1 = 0; r1 = 0; after_edge(); check("seq00_b", {3'b0, q1}, 4'b0000);
        @(negedge clk); s1 = 1; r1 = 0; after_edge(); check("seq10_q", {3'b0, q1}, 4'b0001);
        check("seq10_qb", {3'b0, qb1}, 4'b0000);
        @(negedge clk); s1 = 0; r1 = 0; after_edge(); check("seq00_hold1", {3'b0, q1}, 4'b0001);
        @(negedge clk); s1 = 1; r1 = 1; after_edge(); check("seq11_setdom", {3'b0, q1}, 4'b0001);
        check("seq11_qb", {3'b0, qb1}, 4'b0000);
        @(negedge clk); s1 = 0; r1 = 0; after_edge(); check("seq00_hold2", {3'b0, q1}, 4'b0001);
        @(negedge clk); s1 = 0; r1 = 1; after_edge(); check("seq01_clear", {3'b0, q1}, 4'b0000);

        // Reset-dominant forbidden case
        @(negedge clk); s0 = 1; r0 = 0; after_edge(); check("rd_set", {3'b0, q0}, 4'b0001);
        @(negedge clk); s0 = 1; r0 = 1; after_edge(); check("rd_11_from1_q", {3'b0, q0}, 4'b0000);
        check("rd_11_from1_qb", {3'b0, qb0}, 4'b0001);
        after_edge(); check("rd_11_from0", {3'b0, q0}, 4'b0000);
        @(negedge clk); s0 = 0; r0 = 0;

        // Async reset mid-operation
        s1 = 1; r1 = 0; after_edge(); check("mid_pre_q", {3'b0, q1}, 4'b0001);
        @(negedge clk); s1 = 0; r1 = 0;
        #2 rst = 1'b0;
        #1;
        check("mid_async_q", {3'b0, q1}, 4'b0000);
        check("mid_async_qb", {3'b0, qb1}, 4'b0001);
        @(negedge clk); rst = 1'b1;
        after_edge(); check("mid_release_q", {3'b0, q1}, 4'b0000);

        // Pulses strictly between edges are ignored
        @(negedge clk); #1 s1 = 1; #3 s1 = 0;
        after_edge(); check("between_s", {3'b0, q1}, 4'b0000);
        @(negedge clk); s1 = 1; after_edge(); check("between_setup", {3'b0, q1}, 4'b0001);
        @(negedge clk); s1 = 0; #1 r1 = 1; #3 r1 = 0;
        after_edge(); check("between_r", {3'b0, q1}, 4'b0001);

        // Multi-bit
        @(negedge clk); s4 = 4'b1010; r4 = 4'b0000; after_edge(); check("w4_set", q4, 4'b1010);
        @(negedge clk); s4 = 4'b0001; r4 = 4'b1000; after_edge(); check("w4_mix_q", q4, 4'b0011);
        check("w4_mix_qb", qb4, 4'b1100);
        @(negedge clk); s4 = 4'b0100; r4 = 4'b0110; after_edge(); check("w4_forbid", q4, 4'b0101);
        @(negedge clk); s4 = 4'b0000; r4 = 4'b0000; after_edge(); check("w4_hold", q4, 4'b0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
